// File: rtl/tsv_scan_pkg.sv
// Shared defaults, FSM state encoding and step-width helper for the TSV fault scanner.
package tsv_scan_pkg;

    localparam int unsigned N_TSV_DEF  = 8;
    localparam int unsigned N_RED_DEF  = 2;
    localparam int unsigned SETTLE_DEF = 2;

    // Step counter covers walking-one plus walking-zero phases without wrapping.
    function automatic int unsigned step_width(input int unsigned n_tsv);
        return $clog2(2 * n_tsv);
    endfunction

    localparam int unsigned STEP_W_DEF = step_width(N_TSV_DEF);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/tsv_pattern_gen.sv
// Combinational step-to-pattern map: walking-one for the first N_TSV steps, walking-zero after.
module tsv_pattern_gen
    import tsv_scan_pkg::*;
#(
    parameter int unsigned N_TSV  = N_TSV_DEF,
    parameter int unsigned STEP_W = STEP_W_DEF
) (
    input  logic [STEP_W-1:0] step,
    output logic [N_TSV-1:0]  pattern
);

    logic              walk_zero;
    logic [STEP_W-1:0] lane;

    always_comb begin
        walk_zero = (step >= STEP_W'(N_TSV));
        lane      = walk_zero ? (step - STEP_W'(N_TSV)) : step;
        pattern   = '0;
        for (int unsigned i = 0; i < N_TSV; i++) begin
            pattern[i] = walk_zero ^ (lane == STEP_W'(i));
        end
    end

endmodule

// File: rtl/tsv_fault_scan.sv
// TSV loopback fault scanner: walks one/zero patterns across all lanes and flags any lane
// whose received value ever differs from the driven value.
module tsv_fault_scan
    import tsv_scan_pkg::*;
#(
    parameter int unsigned N_TSV  = N_TSV_DEF,
    parameter int unsigned N_RED  = N_RED_DEF,
    parameter int unsigned SETTLE = SETTLE_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N_TSV-1:0] tsv_rx,
    output logic [N_TSV-1:0] tsv_tx,
    output logic [N_TSV-1:0] f_flag,
    output logic             flag_valid,
    output logic             busy,
    output logic             done,
    output logic             repair_fail
);

    localparam int unsigned STEP_W    = step_width(N_TSV);
    localparam int unsigned LAST_STEP = 2 * N_TSV - 1;
    localparam int unsigned CNT_W     = $clog2(N_TSV + 1);
    localparam int unsigned SET_W     = 4;

    state_t             state, state_nx;
    logic [STEP_W-1:0]  step, step_nx;
    logic [SET_W-1:0]   settle_cnt, settle_cnt_nx;
    logic [N_TSV-1:0]   scratch, scratch_nx;
    logic [N_TSV-1:0]   tx_nx, pattern_nx, f_flag_nx;
    logic               busy_nx, done_nx, flag_valid_nx, repair_fail_nx;
    logic [CNT_W-1:0]   ones;

    // Pattern is looked up for the upcoming step so tsv_tx can be registered.
    tsv_pattern_gen #(
        .N_TSV  (N_TSV),
        .STEP_W (STEP_W)
    ) u_pattern_gen (
        .step    (step_nx),
        .pattern (pattern_nx)
    );

    always_comb begin
        state_nx       = state;
        step_nx        = step;
        settle_cnt_nx  = settle_cnt;
        scratch_nx     = scratch;
        f_flag_nx      = f_flag;
        repair_fail_nx = repair_fail;
        flag_valid_nx  = flag_valid;
        done_nx        = 1'b0;
        ones           = '0;
        for (int unsigned i = 0; i < N_TSV; i++) begin
            ones = ones + CNT_W'(scratch[i]);
        end

        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx      = DRIVE;
                    step_nx       = '0;
                    settle_cnt_nx = '0;
                    scratch_nx    = '0;
                end
            end
            DRIVE: begin
                if (settle_cnt == SET_W'(SETTLE - 1)) begin
                    state_nx = SAMPLE;
                end else begin
                    settle_cnt_nx = settle_cnt + SET_W'(1);
                end
            end
            SAMPLE: begin
                scratch_nx    = scratch | (tsv_rx ^ tsv_tx);
                settle_cnt_nx = '0;
                if (step == STEP_W'(LAST_STEP)) begin
                    state_nx = FINISH;
                end else begin
                    state_nx = DRIVE;
                    step_nx  = step + STEP_W'(1);
                end
            end
            FINISH: begin
                state_nx       = IDLE;
                f_flag_nx      = scratch;
                repair_fail_nx = (ones > CNT_W'(N_RED));
                flag_valid_nx  = 1'b1;
                done_nx        = 1'b1;
            end
            default: state_nx = IDLE;
        endcase

        busy_nx = (state_nx != IDLE);
        tx_nx   = ((state_nx == DRIVE) || (state_nx == SAMPLE)) ? pattern_nx : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            step        <= '0;
            settle_cnt  <= '0;
            scratch     <= '0;
            tsv_tx      <= '0;
            f_flag      <= '0;
            flag_valid  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            repair_fail <= 1'b0;
        end else begin
            state       <= state_nx;
            step        <= step_nx;
            settle_cnt  <= settle_cnt_nx;
            scratch     <= scratch_nx;
            tsv_tx      <= tx_nx;
            f_flag      <= f_flag_nx;
            flag_valid  <= flag_valid_nx;
            busy        <= busy_nx;
            done        <= done_nx;
            repair_fail <= repair_fail_nx;
        end
    end

endmodule

// File: tb/tb_tsv_fault_scan.sv
// Bench for tsv_fault_scan: fault-injecting loopback, cycle-level reference model and directed scans.
module tb_tsv_fault_scan;

    localparam int N        = 8;
    localparam int NRED     = 2;
    localparam int SET      = 2;
    localparam int SCAN_CYC = 2 * N * (SET + 1);

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] tsv_rx, tsv_tx, f_flag;
    logic         flag_valid, busy, done, repair_fail;

    int mode = 0;
    int checks = 0;
    int errors = 0;

    tsv_fault_scan #(.N_TSV(N), .N_RED(NRED), .SETTLE(SET)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .tsv_rx      (tsv_rx),
        .tsv_tx      (tsv_tx),
        .f_flag      (f_flag),
        .flag_valid  (flag_valid),
        .busy        (busy),
        .done        (done),
        .repair_fail (repair_fail)
    );

    always #5 clk = ~clk;

    // Fault injection: 0 ideal, 1 lane3 stuck-0, 2 lanes 1/2 bridged (OR), 3 lanes 0,5,7 stuck-1.
    function automatic logic [N-1:0] fault(input logic [N-1:0] tx, input int m);
        logic [N-1:0] rx;
        logic b;
        rx = tx;
        case (m)
            1: rx = tx & ~8'h08;
            2: begin b = tx[1] | tx[2]; rx[1] = b; rx[2] = b; end
            3: rx = tx | 8'hA1;
            default: rx = tx;
        endcase
        return rx;
    endfunction

    always_comb tsv_rx = fault(tsv_tx, mode);

    function automatic logic [N-1:0] pat(input int s);
        logic [N-1:0] one;
        one = 1;
        return (s < N) ? (one << s) : ~(one << (s - N));
    endfunction

    function automatic logic [N-1:0] scan_result(input int m);
        logic [N-1:0] acc;
        acc = '0;
        for (int s = 0; s < 2 * N; s++) acc |= fault(pat(s), m) ^ pat(s);
        return acc;
    endfunction

    // Reference: t = cycles since the accepting start edge, -1 when idle.
    int           t = -1;
    logic [N-1:0] m_flag = '0, m_pend = '0;
    logic         m_done = 1'b0, m_valid = 1'b0, m_rf = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t = -1; m_done = 1'b0; m_flag = '0; m_valid = 1'b0; m_rf = 1'b0;
        end else begin
            m_done = 1'b0;
            if (t < 0) begin
                if (start) begin t = 0; m_pend = scan_result(mode); end
            end else begin
                t++;
                if (t == SCAN_CYC + 1) begin
                    m_done = 1'b1; m_flag = m_pend; m_valid = 1'b1;
                    m_rf = ($countones(m_pend) > NRED); t = -1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [N-1:0] e_tx;
        e_tx = (t >= 0 && t < SCAN_CYC) ? pat(t / (SET + 1)) : '0;
        check("tx", tsv_tx, e_tx);
        check("f_flag", f_flag, m_flag);
        check("busy", N'(busy), N'(t >= 0));
        check("done", N'(done), N'(m_done));
        check("flag_valid", N'(flag_valid), N'(m_valid));
        check("repair_fail", N'(repair_fail), N'(m_rf));
    end

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 200) begin @(negedge clk); lat++; end
    endtask

    task automatic scan(input int m, input logic [N-1:0] exp_flag, input logic exp_rf);
        int lat;
        mode = m;
        pulse_start();
        wait_done(lat);
        check("latency", N'(lat), N'(49));
        check("lit_f_flag", f_flag, exp_flag);
        check("lit_repair_fail", N'(repair_fail), N'(exp_rf));
        check("lit_flag_valid", N'(flag_valid), N'(1));
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int lat, ndone;
        repeat (2) @(negedge clk);
        check("rst_f_flag", f_flag, '0);
        check("rst_busy", N'(busy), '0);
        check("rst_valid", N'(flag_valid), '0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        scan(0, 8'h00, 1'b0);
        scan(1, 8'h08, 1'b0);
        // Rescan with ideal loopback: old flags must persist until the scan completes.
        mode = 0;
        pulse_start();
        repeat (20) @(negedge clk);
        check("hold_f_flag", f_flag, 8'h08);
        check("hold_valid", N'(flag_valid), N'(1));
        wait_done(lat);
        check("rescan_latency", N'(lat + 20), N'(49));
        check("rescan_f_flag", f_flag, 8'h00);
        repeat (3) @(negedge clk);
        scan(2, 8'h06, 1'b0);
        scan(3, 8'hA1, 1'b1);

        // A second start mid-scan must not be queued.
        mode = 1;
        pulse_start();
        repeat (9) @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                check("ignore_latency", N'(i + 11), N'(49));
            end
        end
        check("ignore_single_done", N'(ndone), N'(1));
        check("ignore_f_flag", f_flag, 8'h08);

        // Reset mid-scan clears everything at once and produces no done.
        pulse_start();
        repeat (19) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", N'(busy), '0);
        check("mid_rst_tx", tsv_tx, '0);
        check("mid_rst_f_flag", f_flag, '0);
        check("mid_rst_valid", N'(flag_valid), '0);
        check("mid_rst_done_rf", N'({done, repair_fail}), '0);
        @(negedge clk); #2 rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("no_done_after_rst", N'(ndone), '0);

        scan(3, 8'hA1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
